// File: rtl/src_alu_bus_mar.sv
// Mini SRC datapath slice: 24-source priority bus, 64-bit-result ALU and 9-bit MAR.
// Define ALU_MULDIV_EN to build the signed multiplier/divider (opcodes 9 and 10).
module src_alu_bus_mar (
  input  logic         clk,
  input  logic         clr,
  input  logic [511:0] r_data,
  input  logic [31:0]  hi_data,
  input  logic [31:0]  lo_data,
  input  logic [31:0]  zhi_data,
  input  logic [31:0]  zlo_data,
  input  logic [31:0]  pc_data,
  input  logic [31:0]  mdr_data,
  input  logic [31:0]  inport_data,
  input  logic [31:0]  csign_data,
  input  logic [15:0]  r_out,
  input  logic         hi_out,
  input  logic         lo_out,
  input  logic         zhi_out,
  input  logic         zlo_out,
  input  logic         pc_out,
  input  logic         mdr_out,
  input  logic         inport_out,
  input  logic         c_out,
  input  logic [31:0]  y_data,
  input  logic [4:0]   alu_control,
  input  logic         mar_en,
  output logic [31:0]  bus_out,
  output logic [63:0]  alu_result,
  output logic [8:0]   address
);

  // Source index doubles as priority: lower index wins.
  logic [31:0] src [24];
  logic [23:0] sel;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_reg_src
      assign src[gi] = r_data[32*gi +: 32];
    end
  endgenerate

  assign src[16] = hi_data;
  assign src[17] = lo_data;
  assign src[18] = zhi_data;
  assign src[19] = zlo_data;
  assign src[20] = pc_data;
  assign src[21] = mdr_data;
  assign src[22] = inport_data;
  assign src[23] = csign_data;
  assign sel = {c_out, inport_out, mdr_out, pc_out, zlo_out, zhi_out, lo_out, hi_out, r_out};

  always_comb begin
    bus_out = '0;
    for (int i = 23; i >= 0; i--) begin
      if (sel[i]) bus_out = src[i];
    end
  end

  logic [31:0] a, b, sra;
  logic [4:0]  amt;
  logic [63:0] rot_r, rot_l;

  assign a     = y_data;
  assign b     = bus_out;
  assign amt   = b[4:0];
  assign sra   = $signed(a) >>> amt;
  assign rot_r = {a, a} >> amt;
  assign rot_l = {a, a} << amt;

`ifdef ALU_MULDIV_EN
  logic signed [63:0] prod;
  logic [31:0]        quot, rem;

  assign prod = $signed(a) * $signed(b);

  // Divide-by-zero and the single overflow case are pinned explicitly.
  always_comb begin
    if (b == 32'd0) begin
      quot = 32'd0;
      rem  = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end else begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end
  end
`endif

  always_comb begin
    alu_result = '0;
    case (alu_control)
      5'd0:  alu_result = {32'd0, a + b};
      5'd1:  alu_result = {32'd0, a - b};
      5'd2:  alu_result = {32'd0, a & b};
      5'd3:  alu_result = {32'd0, a | b};
      5'd4:  alu_result = {32'd0, a >> amt};
      5'd5:  alu_result = {32'd0, sra};
      5'd6:  alu_result = {32'd0, a << amt};
      5'd7:  alu_result = {32'd0, rot_r[31:0]};
      5'd8:  alu_result = {32'd0, rot_l[63:32]};
`ifdef ALU_MULDIV_EN
      5'd9:  alu_result = prod;
      5'd10: alu_result = {rem, quot};
`endif
      5'd11: alu_result = {32'd0, 32'd0 - b};
      5'd12: alu_result = {32'd0, ~b};
      5'd13: alu_result = {32'd0, b + 32'd4};
      default: alu_result = '0;
    endcase
  end

  logic [8:0] address_d, address_q;

  always_comb begin
    address_d = address_q;
    if (mar_en) address_d = bus_out[8:0];
  end

  always_ff @(posedge clk) begin
    if (!clr) address_q <= '0;
    else      address_q <= address_d;
  end

  assign address = address_q;

endmodule

// File: tb/tb_src_alu_bus_mar.sv
// Randomized and directed bench for src_alu_bus_mar against an arithmetic reference model.
module tb_src_alu_bus_mar;

  logic         clk = 1'b0;
  logic         clr;
  logic [511:0] r_data;
  logic [31:0]  hi_data, lo_data, zhi_data, zlo_data, pc_data, mdr_data, inport_data, csign_data;
  logic [15:0]  r_out;
  logic         hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
  logic [31:0]  y_data;
  logic [4:0]   alu_control;
  logic         mar_en;
  logic [31:0]  bus_out;
  logic [63:0]  alu_result;
  logic [8:0]   address;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  logic [8:0] mar_model;

  always #5 clk = ~clk;

  src_alu_bus_mar dut (
    .clk(clk), .clr(clr), .r_data(r_data),
    .hi_data(hi_data), .lo_data(lo_data), .zhi_data(zhi_data), .zlo_data(zlo_data),
    .pc_data(pc_data), .mdr_data(mdr_data), .inport_data(inport_data), .csign_data(csign_data),
    .r_out(r_out), .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
    .pc_out(pc_out), .mdr_out(mdr_out), .inport_out(inport_out), .c_out(c_out),
    .y_data(y_data), .alu_control(alu_control), .mar_en(mar_en),
    .bus_out(bus_out), .alu_result(alu_result), .address(address)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // Bus model: gather every driving source in priority order, first one wins.
  function automatic logic [31:0] ref_bus();
    logic [31:0] cand [$];
    for (int n = 0; n < 16; n++) if (r_out[n]) cand.push_back(r_data[32*n +: 32]);
    if (hi_out)     cand.push_back(hi_data);
    if (lo_out)     cand.push_back(lo_data);
    if (zhi_out)    cand.push_back(zhi_data);
    if (zlo_out)    cand.push_back(zlo_data);
    if (pc_out)     cand.push_back(pc_data);
    if (mdr_out)    cand.push_back(mdr_data);
    if (inport_out) cand.push_back(inport_data);
    if (c_out)      cand.push_back(csign_data);
    if (cand.size() == 0) return 32'd0;
    return cand[0];
  endfunction

  // ALU model from plain arithmetic: shifts as scaling, rotates as bit-by-bit steps.
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          n;
    logic [31:0] lo;
    longint      sa, sb, q, r, p;
    longint unsigned ua, scale;
    n     = int'(b[4:0]);
    ua    = {32'd0, a};
    scale = 64'd1 << n;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    lo    = 32'd0;
    case (op)
      5'd0:  lo = 32'(ua + {32'd0, b});
      5'd1:  lo = 32'(ua + 64'h1_0000_0000 - {32'd0, b});
      5'd2:  lo = a & b;
      5'd3:  lo = a | b;
      5'd4:  lo = 32'(ua / scale);
      5'd5:  lo = a[31] ? ~32'({32'd0, ~a} / scale) : 32'(ua / scale);
      5'd6:  lo = 32'(ua * scale);
      5'd7:  begin lo = a; for (int k = 0; k < n; k++) lo = {lo[0], lo[31:1]}; end
      5'd8:  begin lo = a; for (int k = 0; k < n; k++) lo = {lo[30:0], lo[31]}; end
`ifdef ALU_MULDIV_EN
      5'd9:  begin p = sa * sb; return 64'(p); end
      5'd10: begin
        if (b == 32'd0) return {a, 32'd0};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
`endif
      5'd11: lo = 32'(64'h1_0000_0000 - {32'd0, b});
      5'd12: lo = ~b;
      5'd13: lo = 32'({32'd0, b} + 64'd4);
      default: lo = 32'd0;
    endcase
    return {32'd0, lo};
  endfunction

  task automatic clear_sel();
    r_out = '0; hi_out = 0; lo_out = 0; zhi_out = 0; zlo_out = 0;
    pc_out = 0; mdr_out = 0; inport_out = 0; c_out = 0;
  endtask

  // One transaction: settle, check bus/ALU, clock once, check MAR.
  task automatic run_txn(input string tag);
    logic [31:0] eb;
    logic [63:0] er;
    #1;
    eb = ref_bus();
    er = ref_alu(alu_control, y_data, eb);
    check_val({tag, ".bus"}, {32'd0, bus_out}, {32'd0, eb});
    check_val({tag, ".alu"}, alu_result, er);
    @(posedge clk);
    if (!clr)        mar_model = 9'd0;
    else if (mar_en) mar_model = eb[8:0];
    #1;
    check_val({tag, ".mar"}, {55'd0, address}, {55'd0, mar_model});
    n_txn++;
    $display("txn %0d %s op=%0d y=%h bus=%h res=%h addr=%h", n_txn, tag, alu_control, y_data, bus_out, alu_result, address);
  endtask

  task automatic alu_case(input string tag, input logic [4:0] op, input logic [31:0] y,
                          input logic [31:0] bval, input logic [63:0] exp);
    clear_sel();
    hi_data = bval; hi_out = 1; y_data = y; alu_control = op;
    #1;
    check_val({tag, ".spec"}, alu_result, exp);
    run_txn(tag);
  endtask

  initial begin
    r_data = '0; hi_data = 0; lo_data = 0; zhi_data = 0; zlo_data = 0; pc_data = 0;
    mdr_data = 0; inport_data = 0; csign_data = 0; y_data = 0; alu_control = 0;
    clear_sel();
    clr = 0; mar_en = 1;
    mar_model = 9'd0;
    r_data[32*0 +: 32] = 32'h1FF;
    r_out[0] = 1;
    run_txn("reset");          // reset overrides a pending load
    clr = 1; mar_en = 0;

    // Bus priority
    clear_sel();
    r_data[32*3 +: 32] = 32'h11; pc_data = 32'h22; r_out[3] = 1; pc_out = 1;
    #1; check_val("prio.r3", {32'd0, bus_out}, 64'h11);
    run_txn("prio1");
    r_out[3] = 0;
    #1; check_val("prio.pc", {32'd0, bus_out}, 64'h22);
    run_txn("prio2");
    pc_out = 0;
    #1; check_val("prio.none", {32'd0, bus_out}, 64'h0);
    run_txn("prio3");

    alu_case("add",  5'd0,  32'h7, 32'h5, 64'hC);
    alu_case("sub",  5'd1,  32'h5, 32'h7, 64'h0000_0000_FFFF_FFFE);
    alu_case("shr",  5'd4,  32'h8000_0001, 32'h21, 64'h4000_0000);
    alu_case("shra", 5'd5,  32'h8000_0001, 32'h21, 64'hC000_0000);
    alu_case("shl",  5'd6,  32'h8000_0001, 32'h21, 64'h2);
    alu_case("ror",  5'd7,  32'h8000_0001, 32'h21, 64'hC000_0000);
    alu_case("rol",  5'd8,  32'h8000_0001, 32'h21, 64'h3);
    alu_case("sh0",  5'd7,  32'h8000_0001, 32'h20, 64'h8000_0001);
`ifdef ALU_MULDIV_EN
    alu_case("mul",  5'd9,  32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    alu_case("div",  5'd10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    alu_case("div0", 5'd10, 32'h1234_5678, 32'd0, 64'h1234_5678_0000_0000);
    alu_case("divov",5'd10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
`else
    alu_case("mul",  5'd9,  32'hFFFF_FFFD, 32'd7, 64'h0);
    alu_case("div",  5'd10, 32'hFFFF_FFF9, 32'd2, 64'h0);
`endif
    alu_case("neg",  5'd11, 32'h0, 32'h1, 64'hFFFF_FFFF);
    alu_case("not",  5'd12, 32'h0, 32'h1, 64'hFFFF_FFFE);
    alu_case("inc4", 5'd13, 32'h0, 32'h1, 64'h5);
    alu_case("op20", 5'd20, 32'hFFFF_FFFF, 32'h1, 64'h0);

    // MAR load, hold, reset
    clear_sel(); hi_data = 32'h1234; hi_out = 1; mar_en = 1;
    run_txn("marld");
    check_val("mar.load", {55'd0, address}, 64'h34);
    mar_en = 0; hi_data = 32'h0ABC;
    run_txn("marhold");
    check_val("mar.hold", {55'd0, address}, 64'h34);
    clr = 0; mar_en = 1;
    run_txn("marclr");
    check_val("mar.clr", {55'd0, address}, 64'h0);
    clr = 1;
    run_txn("marrel");

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      for (int n = 0; n < 16; n++) r_data[32*n +: 32] = $urandom;
      hi_data = $urandom; lo_data = $urandom; zhi_data = $urandom; zlo_data = $urandom;
      pc_data = $urandom; mdr_data = $urandom; inport_data = $urandom; csign_data = $urandom;
      r_out = 16'($urandom & $urandom & $urandom & $urandom);
      {hi_out, lo_out, zhi_out, zlo_out} = 4'($urandom & $urandom & $urandom);
      {pc_out, mdr_out, inport_out, c_out} = 4'($urandom & $urandom & $urandom);
      y_data = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0: begin clear_sel(); hi_out = 1; hi_data = 32'd0; end
        1: begin clear_sel(); lo_out = 1; lo_data = 32'hFFFF_FFFF; end
        default: ;
      endcase
      alu_control = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(14, 31)) : 5'($urandom_range(0, 13));
      mar_en = 1'($urandom_range(0, 1));
      clr    = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      run_txn("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/src_alu_bus_mar.md
# src_alu_bus_mar

Datapath core slice for the Mini SRC processor. It combines three parts:
- a 24-source, 32-bit one-hot bus multiplexer;
- a combinational 64-bit-result ALU fed by the bus and the Y operand;
- the 9-bit Memory Address Register (MAR) that captures the bus for RAM addressing.

It sits between the register file, PC, MDR, HI/LO and Z registers and the RAM.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-low reset
- r_data  in  512  R0..R15 contents; Rn at [32n+31:32n]
- hi_data, lo_data, zhi_data, zlo_data, pc_data, mdr_data, inport_data, csign_data  in  32 each  other bus sources
- r_out  in  16  Rn drives bus when r_out[n]=1
- hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out  in  1 each  source selects
- y_data  in  32  Y register (ALU operand A)
- alu_control  in  5  operation code
- mar_en  in  1  MAR load enable
- bus_out  out  32  bus value (ALU operand B)
- alu_result  out  64  {high, low} result
- address  out  9  MAR contents

## Operation
- Bus priority, fixed, highest first: R0..R15, HI, LO, ZHI, ZLO, PC, MDR, InPort, C.
  - Several selects asserted: the highest-priority one wins.
  - No select asserted: bus_out = 0.
- ALU operands: A = y_data, B = bus_out. Results are listed as low32 / high32.
  - 0 ADD: A+B / 0; carry discarded.
  - 1 SUB: A−B / 0; wraps mod 2^32.
  - 2 AND: A&B / 0.
  - 3 OR: A|B / 0.
  - 4 SHR: A>>B[4:0], logical / 0.
  - 5 SHRA: A>>>B[4:0], arithmetic / 0.
  - 6 SHL: A<<B[4:0] / 0.
  - 7 ROR: A rotated right by B[4:0] / 0.
  - 8 ROL: A rotated left by B[4:0] / 0.
  - 9 MUL: signed A×B, full 64-bit product.
  - 10 DIV: signed A÷B; quotient in low, remainder in high.
    - Truncates toward zero; remainder takes the sign of A.
    - B=0: quotient 0, remainder A.
    - A=0x80000000, B=−1: quotient 0x80000000, remainder 0.
  - 11 NEG: −B / 0.
  - 12 NOT: ~B / 0.
  - 13 INC4: B+4 / 0.
  - 14–31: 0 / 0.
- Shift amounts use only B[4:0]; an amount of 0 passes A through unchanged.
- MAR: on rising clk with clr=1 and mar_en=1, address ← bus_out[8:0]; otherwise it holds.

## Timing
- bus_out and alu_result are purely combinational with zero-cycle latency; they change in the same cycle as any input.
- address updates one cycle after mar_en is sampled high.
- Reset: clr=0 at a rising clk forces address to 0. This overrides mar_en and is independent of bus activity.
- Reset value of address is 0. bus_out and alu_result have no reset; they follow their inputs at all times, including during reset.
- Before the first clk edge with clr=0, address is undefined.
- If clr deasserts in the same cycle as mar_en=1, the load takes effect at the first edge where clr=1.

## Configuration
- ALU_MULDIV_EN
  - Defined: opcodes 9 (MUL) and 10 (DIV) behave as specified.
  - Undefined: no multiplier or divider is built, and opcodes 9 and 10 give alu_result = 0, like opcodes 14–31.
  - All other behaviour is identical in both builds.

## Test plan
- Bus priority: R3=0x11, PC=0x22, r_out[3]=1, pc_out=1 -> bus_out=0x11. Then drop r_out[3] -> 0x22. Then drop pc_out -> 0.
- Add/subtract: y=0x7, R1=0x5, select R1.
  - op 0 -> alu_result=0x0000_0000_0000_000C.
  - op 1 with y=0x5, R1=0x7 -> low=0xFFFFFFFE, high=0.
- Shifts and rotates: y=0x80000001, bus=0x21 (amount 1).
  - SHR -> 0x40000000.
  - SHRA -> 0xC0000000.
  - SHL -> 0x00000002.
  - ROR -> 0xC0000000.
  - ROL -> 0x00000003.
- MUL/DIV (ALU_MULDIV_EN defined):
  - y=−3, bus=7, MUL -> 0xFFFFFFFF_FFFFFFEB.
  - y=−7, bus=2, DIV -> low=0xFFFFFFFD, high=0xFFFFFFFF.
  - bus=0, DIV -> low=0, high=y.
  - Without the macro, MUL -> 0.
- MAR:
  - bus=0x1234, mar_en=1, one edge -> address=0x034.
  - mar_en=0 with bus changing -> address holds.
  - clr=0 with mar_en=1 -> address=0 after the edge.
- NEG/NOT/INC4 with bus=0x1:
  - NEG -> 0xFFFFFFFF.
  - NOT -> 0xFFFFFFFE.
  - INC4 -> 0x5.
  - op 20 -> 0.
